// File: rtl/pipeline_boot_ctrl.sv
// rtl/pipeline_boot_ctrl.sv - boot/run sequencer: clears, loads and runs the 8-bit RISC-V pipeline core
//
// Clears the core instruction memory, loads prog_len 32-bit little-endian words from a byte
// stream into the core through its instruction-memory write port, then releases core reset for
// run_limit cycles (or until stop when run_limit is 0) and reports completion.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   defined   - one trailing checksum byte (8-bit sum of all program bytes) is accepted after the
//               last word; a mismatch ends in DONE with err=1 without releasing the core.
//   undefined - no checksum byte, err tied low.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   start            in   begin sequence (honoured in IDLE or DONE)
//   prog_len         in   words to load, latched on accepted start
//   run_limit        in   core run cycles, latched on accepted start (0 = run until stop)
//   stop             in   terminate RUN
//   byte_valid       in   program byte available
//   byte_data        in   program byte
//   byte_ready       out  controller accepts a byte this cycle
//   core_reset       out  core reset
//   core_reset_mem   out  core reset_IF_memory
//   core_rw          out  core rw (1 = write instruction memory)
//   core_pc_write    out  core PC_write
//   core_instruction out  core instruction_in
//   busy             out  sequence in progress
//   done             out  run finished
//   err              out  checksum failure
module pipeline_boot_ctrl #(
    parameter int PC_SIZE      = 10,
    parameter int PC_STEP      = 4,
    parameter int CLEAR_CYCLES = 2,
    parameter int RUN_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_SIZE-1:0] prog_len,
    input  logic [RUN_W-1:0]   run_limit,
    input  logic               stop,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               core_reset,
    output logic               core_reset_mem,
    output logic               core_rw,
    output logic [PC_SIZE-1:0] core_pc_write,
    output logic [31:0]        core_instruction,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]   CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [PC_SIZE-1:0] STEP     = PC_SIZE'(PC_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CLR_W-1:0]   clr_cnt;
    logic [1:0]         byte_idx;
    logic [PC_SIZE-1:0] word_idx;
    logic [PC_SIZE-1:0] prog_len_q;
    logic [RUN_W-1:0]   run_limit_q;
    logic [RUN_W-1:0]   run_cnt;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]         sum;
`else
    assign err = 1'b0;
`endif

    // Every output is a register updated on the same edge as the state it belongs to, so the
    // outputs always describe the current state rather than lagging it by a cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            clr_cnt          <= '0;
            byte_idx         <= '0;
            word_idx         <= '0;
            prog_len_q       <= '0;
            run_limit_q      <= '0;
            run_cnt          <= '0;
            byte_ready       <= 1'b0;
            core_reset       <= 1'b1;
            core_reset_mem   <= 1'b0;
            core_rw          <= 1'b0;
            core_pc_write    <= '0;
            core_instruction <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            err              <= 1'b0;
            sum              <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_CLEAR;
                        prog_len_q     <= prog_len;
                        run_limit_q    <= run_limit;
                        clr_cnt        <= '0;
                        byte_idx       <= '0;
                        word_idx       <= '0;
                        run_cnt        <= '0;
                        core_reset     <= 1'b1;
                        core_reset_mem <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        err            <= 1'b0;
                        sum            <= '0;
`endif
                    end
                end

                S_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        core_reset_mem <= 1'b0;
                        if (prog_len_q != '0) begin
                            state      <= S_LOAD;
                            byte_ready <= 1'b1;
                        end else begin
                            state      <= S_RUN;
                            core_reset <= 1'b0;
                            run_cnt    <= '0;
                        end
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end

                S_LOAD: begin
                    // byte_ready is high throughout LOAD, so byte_valid alone marks a transfer.
                    if (byte_valid) begin
                        core_instruction[{byte_idx, 3'b000} +: 8] <= byte_data;
                        byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                        sum      <= sum + byte_data;
`endif
                        if (byte_idx == 2'd3) begin
                            state         <= S_WRITE;
                            byte_ready    <= 1'b0;
                            core_rw       <= 1'b1;
                            core_pc_write <= word_idx * STEP;
                        end
                    end
                end

                S_WRITE: begin
                    core_rw  <= 1'b0;
                    word_idx <= word_idx + PC_SIZE'(1);
                    if (word_idx + PC_SIZE'(1) == prog_len_q) begin
`ifdef BOOT_CHECKSUM_EN
                        state      <= S_CHECK;
                        byte_ready <= 1'b1;
`else
                        state      <= S_RUN;
                        core_reset <= 1'b0;
                        run_cnt    <= '0;
`endif
                    end else begin
                        // byte_idx has already wrapped to 0 after the fourth byte.
                        state      <= S_LOAD;
                        byte_ready <= 1'b1;
                    end
                end

`ifdef BOOT_CHECKSUM_EN
                S_CHECK: begin
                    if (byte_valid) begin
                        byte_ready <= 1'b0;
                        if (byte_data == sum) begin
                            state      <= S_RUN;
                            core_reset <= 1'b0;
                            run_cnt    <= '0;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                S_RUN: begin
                    // stop takes priority; a zero limit never matches so only stop can end the run.
                    if (stop || (run_limit_q != '0 && run_cnt == run_limit_q - RUN_W'(1))) begin
                        state      <= S_DONE;
                        core_reset <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + RUN_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_boot_ctrl.sv
// tb/tb_pipeline_boot_ctrl.sv - directed self-checking bench for pipeline_boot_ctrl
module tb_pipeline_boot_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  prog_len;
    logic [15:0] run_limit;
    logic        stop;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        core_reset;
    logic        core_reset_mem;
    logic        core_rw;
    logic [9:0]  core_pc_write;
    logic [31:0] core_instruction;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Cycle monitor: event counters sampled on the rising edge.
    int          wr_n     = 0;
    logic [9:0]  wr_pc   [0:31];
    logic [31:0] wr_data [0:31];
    int          low_n    = 0;
    int          mem_n    = 0;
    int          rdy_n    = 0;
    int          xfer_n   = 0;

    always #5 clock = ~clock;

    pipeline_boot_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .prog_len         (prog_len),
        .run_limit        (run_limit),
        .stop             (stop),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_ready       (byte_ready),
        .core_reset       (core_reset),
        .core_reset_mem   (core_reset_mem),
        .core_rw          (core_rw),
        .core_pc_write    (core_pc_write),
        .core_instruction (core_instruction),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always @(posedge clock) begin
        if (core_rw === 1'b1) begin
            if (wr_n < 32) begin
                wr_pc[wr_n]   = core_pc_write;
                wr_data[wr_n] = core_instruction;
            end
            wr_n = wr_n + 1;
        end
        if (core_reset === 1'b0)     low_n  = low_n + 1;
        if (core_reset_mem === 1'b1) mem_n  = mem_n + 1;
        if (byte_ready === 1'b1)     rdy_n  = rdy_n + 1;
        if (byte_ready === 1'b1 && byte_valid === 1'b1) xfer_n = xfer_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [9:0] len, input logic [15:0] lim);
        prog_len  = len;
        run_limit = lim;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("byte_accept_in_time", 32'(n < 200), 32'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_reset"}, 32'(core_reset),     32'd1);
        check({tag, "_reset_mem"},  32'(core_reset_mem), 32'd0);
        check({tag, "_rw"},         32'(core_rw),        32'd0);
        check({tag, "_pc"},         32'(core_pc_write),  32'd0);
        check({tag, "_instr"},      core_instruction,    32'd0);
        check({tag, "_ready"},      32'(byte_ready),     32'd0);
        check({tag, "_busy"},       32'(busy),           32'd0);
        check({tag, "_done"},       32'(done),           32'd0);
        check({tag, "_err"},        32'(err),            32'd0);
    endtask

    initial begin
        int wb, lb, mb, rb, xb;

        reset      = 1'b1;
        start      = 1'b0;
        prog_len   = '0;
        run_limit  = '0;
        stop       = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (2) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Two-word program, 5-cycle run.
        wb = wr_n; lb = low_n;
        pulse_start(10'd2, 16'd5);
        check("t1_busy", 32'(busy), 32'd1);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h20, 0); send_byte(8'h00, 0);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'hD6, 0);
`endif
        wait_done("t1_done");
        check("t1_writes", 32'(wr_n - wb), 32'd2);
        check("t1_pc0",    32'(wr_pc[wb]),     32'd0);
        check("t1_data0",  wr_data[wb],        32'h0010_0013);
        check("t1_pc1",    32'(wr_pc[wb + 1]), 32'd4);
        check("t1_data1",  wr_data[wb + 1],    32'h0020_0093);
        check("t1_low",    32'(low_n - lb),    32'd5);
        check("t1_busy_end", 32'(busy),        32'd0);
        check("t1_core_reset_end", 32'(core_reset), 32'd1);
        check("t1_err",    32'(err),           32'd0);

        // Empty program goes straight from CLEAR to RUN.
        wb = wr_n; lb = low_n; mb = mem_n; rb = rdy_n;
        pulse_start(10'd0, 16'd3);
        check("t2_done_cleared", 32'(done), 32'd0);
        wait_done("t2_done");
        check("t2_mem_clear", 32'(mem_n - mb), 32'd2);
        check("t2_no_ready",  32'(rdy_n - rb), 32'd0);
        check("t2_no_write",  32'(wr_n - wb),  32'd0);
        check("t2_low",       32'(low_n - lb), 32'd3);

        // byte_valid toggled every other cycle during a one-word load.
        wb = wr_n; lb = low_n; xb = xfer_n;
        pulse_start(10'd1, 16'd2);
        send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 1);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h38, 1);
        check("t3_xfers", 32'(xfer_n - xb), 32'd5);
`else
        check("t3_xfers", 32'(xfer_n - xb), 32'd4);
`endif
        wait_done("t3_done");
        check("t3_writes", 32'(wr_n - wb),  32'd1);
        check("t3_pc",     32'(wr_pc[wb]),  32'd0);
        check("t3_data",   wr_data[wb],     32'hDEAD_BEEF);
        check("t3_low",    32'(low_n - lb), 32'd2);

        // Open-ended run ended by stop; start during RUN is ignored.
        lb = low_n; mb = mem_n;
        pulse_start(10'd0, 16'd0);
        begin
            int n;
            n = 0;
            while (core_reset !== 1'b0 && n < 50) begin
                tick();
                n++;
            end
            check("t4_run_entered", 32'(core_reset), 32'd0);
        end
        mb = mem_n;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_start_ignored_mem", 32'(core_reset_mem), 32'd0);
        check("t4_still_running",     32'(core_reset),     32'd0);
        repeat (6) tick();
        check("t4_no_done_yet", 32'(done), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4_done_after_stop", 32'(done), 32'd1);
        check("t4_core_held",       32'(core_reset), 32'd1);
        check("t4_low",             32'(low_n - lb), 32'd11);
        check("t4_no_clear",        32'(mem_n - mb), 32'd0);

        // Reset in the middle of the second word, then a fresh load from pc 0.
        pulse_start(10'd2, 16'd4);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        reset = 1'b0;
        tick();
        wb = wr_n; lb = low_n;
        pulse_start(10'd1, 16'd1);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h0A, 0);
`endif
        wait_done("t5_done");
        check("t5_writes", 32'(wr_n - wb),  32'd1);
        check("t5_pc",     32'(wr_pc[wb]),  32'd0);
        check("t5_data",   wr_data[wb],     32'h0403_0201);
        check("t5_low",    32'(low_n - lb), 32'd1);

`ifdef BOOT_CHECKSUM_EN
        // Matching checksum runs the core; mismatching one flags err and never releases it.
        lb = low_n;
        pulse_start(10'd1, 16'd2);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h0A, 0);
        wait_done("t6_done_ok");
        check("t6_err_ok", 32'(err),         32'd0);
        check("t6_low_ok", 32'(low_n - lb),  32'd2);
        lb = low_n;
        pulse_start(10'd1, 16'd2);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h0B, 0);
        wait_done("t6_done_bad");
        check("t6_err_bad", 32'(err),        32'd1);
        check("t6_low_bad", 32'(low_n - lb), 32'd0);
`else
        check("t6_err_tied", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_boot_ctrl.md
Name: pipeline_boot_ctrl

Overview:
Boot/run sequencer for the 8-bit RISC-V pipeline core. Clears the core's instruction memory and loads a program from a byte-wide valid/ready stream, assembling 32-bit little-endian words and writing each through the core's instruction-memory write port. It then releases core reset for a bounded or open-ended run and reports completion. Sits between the test/host interface and the core's clock, reset, rw, reset_IF_memory, PC_write and instruction_in pins.

Parameters:
PC_SIZE, 10, width of the core PC and of core_pc_write and prog_len
PC_STEP, 4, byte-address increment per loaded word
CLEAR_CYCLES, 2, cycles core_reset_mem is held high in CLEAR (must be ≥1)
RUN_W, 16, width of run_limit and the run cycle counter

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; one clock, this reset is synchronous active-high
start  in  1  begin sequence; honoured only in IDLE or DONE
prog_len  in  PC_SIZE  number of 32-bit words to load, sampled on accepted start
run_limit  in  RUN_W  core run cycles, sampled on accepted start; 0 = run until stop
stop  in  1  terminate RUN
byte_valid  in  1  program byte available
byte_data  in  8  program byte
byte_ready  out  1  controller accepts byte this cycle
core_reset  out  1  drives core reset
core_reset_mem  out  1  drives core reset_IF_memory
core_rw  out  1  drives core rw (1 = write instruction memory)
core_pc_write  out  PC_SIZE  drives core PC_write
core_instruction  out  32  drives core instruction_in
busy  out  1  high in CLEAR, LOAD, WRITE, RUN
done  out  1  high in DONE
err  out  1  checksum failure flag (see Optional Feature)

Behaviour:
- Reset values: state IDLE, core_reset=1, core_reset_mem=0, core_rw=0, core_pc_write=0, core_instruction=0, byte_ready=0, busy=0, done=0, err=0; word index, byte index, counters, latched prog_len/run_limit = 0.
- All outputs registered; state change takes effect the cycle after its condition.
- IDLE: core_reset=1. start → CLEAR; latch prog_len, run_limit.
- CLEAR: core_reset=1, core_reset_mem=1 for exactly CLEAR_CYCLES cycles; then → LOAD if prog_len≠0, else → RUN.
- LOAD: byte_ready=1, core_reset=1. Transfer on byte_valid&byte_ready. Byte k (k=0..3) goes to core_instruction[8k+7:8k]; first byte is LSB. Fourth transfer → WRITE. byte_valid low: wait indefinitely, no timeout.
- WRITE: one cycle; byte_ready=0, core_rw=1, core_pc_write = word_index*PC_STEP mod 2^PC_SIZE, core_instruction holds assembled word. Then word_index++; if new index == prog_len → RUN, else → LOAD with byte index 0. core_rw is never high outside WRITE.
- RUN: core_reset=0, counter from 0 increments each cycle. run_limit≠0 and counter == run_limit−1 → DONE (core out of reset exactly run_limit cycles). stop → DONE immediately (stop wins over limit in the same cycle). run_limit=0: only stop exits.
- DONE: core_reset=1, done=1 held; start → CLEAR (done cleared, err cleared, indices cleared, new values latched).
- start outside IDLE/DONE ignored. stop outside RUN ignored.
- Reset mid-operation (any state): immediate return to reset values; partially assembled word discarded; memory contents undefined and cleared on the next CLEAR.

Optional Feature:
BOOT_CHECKSUM_EN. Defined: 8-bit modular sum of all program bytes accumulated during LOAD; after the last WRITE, state CHECK accepts one more byte (byte_ready=1). byte == sum → RUN; mismatch → DONE with err=1, core never released. Undefined: no CHECK state, no extra byte, err tied 0.

Test Plan:
- Reset, start with prog_len=2, run_limit=5, bytes 13 00 10 00 93 00 20 00 → two WRITE pulses: pc 0 data 0x00100013, pc 4 data 0x00200093; core_reset low exactly 5 cycles; done=1.
- prog_len=0, run_limit=3 → CLEAR 2 cycles with core_reset_mem=1, no byte_ready, RUN 3 cycles, DONE.
- byte_valid toggled every other cycle during 1-word load → word assembled correctly, single WRITE, no extra transfers.
- run_limit=0, stop asserted 10 cycles into RUN → DONE next cycle; start during RUN beforehand ignored.
- reset asserted after 2 bytes of word 1 → all outputs at reset values next cycle; fresh start reloads from pc 0.
- BOOT_CHECKSUM_EN: bytes 01 02 03 04 then checksum 0x0A → RUN; checksum 0x0B → DONE, err=1, core_reset never low.
